// File: rtl/adder_rr_arbiter_if.sv
// Request/result bundle between the convolution partial-sum producers, the
// shared saturating adder and the accumulation stage.
interface adder_rr_arbiter_if #(
  parameter int data_width = 17,
  parameter int num_req    = 4,
  parameter int id_width   = $clog2(num_req)
);
  logic [num_req-1:0]            req_valid;
  logic [num_req-1:0]            req_ready;
  logic [num_req*data_width-1:0] req_data_1;
  logic [num_req*data_width-1:0] req_data_2;
  logic                          res_valid;
  logic                          res_ready;
  logic [data_width-1:0]         res_sum;
  logic [id_width-1:0]           res_id;
  logic                          res_sat;

  // slave: the arbiter itself; master: the producers and consumer around it.
  modport slave (
    input  req_valid, req_data_1, req_data_2, res_ready,
    output req_ready, res_valid, res_sum, res_id, res_sat
  );

  modport master (
    output req_valid, req_data_1, req_data_2, res_ready,
    input  req_ready, res_valid, res_sum, res_id, res_sat
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin scheduler sharing one saturating signed adder among num_req
// requesters; results are returned tagged with the owning requester index.
module adder_rr_arbiter #(
  parameter int data_width = 17,
  parameter int num_req    = 4,
  parameter int id_width   = $clog2(num_req)
) (
  input logic               clock,
  input logic               reset,
  adder_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADD, OUT} state_e;

  localparam int                    iw1       = id_width + 1;
  localparam logic [id_width:0]     num_req_w = iw1'(num_req);
  localparam logic [id_width-1:0]   last_rst  = id_width'(num_req - 1);
  localparam logic [data_width-1:0] sat_max   = {1'b0, {(data_width-1){1'b1}}};
  localparam logic [data_width-1:0] sat_min   = {1'b1, {(data_width-1){1'b0}}};

  state_e                state_q, state_d;
  logic [data_width-1:0] a_q, a_d, b_q, b_d;
  logic [data_width-1:0] sum_q, sum_d;
  logic [id_width-1:0]   grant_q, grant_d, last_q, last_d, id_q, id_d;
  logic                  sat_q, sat_d;

  logic                  win_found;
  logic [id_width-1:0]   win_id;
  logic [data_width-1:0] a_sel, b_sel;
  logic [num_req-1:0]    grant_oh;
  logic [data_width-1:0] sm;
  logic                  ovf, und;

  // Search starts one past the last grant so the previous winner ranks lowest.
  always_comb begin : pick
    logic [id_width:0] idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_id    = last_q;
    idx       = '0;
    for (int k = 1; k <= num_req; k++) begin
      idx = {1'b0, last_q} + iw1'(k);
      if (idx >= num_req_w) idx = idx - num_req_w;
      if (!win_found && bus.req_valid[idx[id_width-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[id_width-1:0];
      end
    end
  end

  always_comb begin : operand_mux
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < num_req; i++) begin
      if (win_id == id_width'(i)) begin
        a_sel = bus.req_data_1[i*data_width +: data_width];
        b_sel = bus.req_data_2[i*data_width +: data_width];
      end
    end
  end

  // Overflow is only possible when both operands share a sign the sum lacks.
  assign sm  = a_q + b_q;
  assign ovf = ~a_q[data_width-1] & ~b_q[data_width-1] &  sm[data_width-1];
  assign und =  a_q[data_width-1] &  b_q[data_width-1] & ~sm[data_width-1];

  always_comb begin : fsm_next
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    grant_d  = grant_q;
    last_d   = last_q;
    sum_d    = sum_q;
    id_d     = id_q;
    sat_d    = sat_q;
    grant_oh = '0;
    unique case (state_q)
      IDLE: begin
        // Reset wins over a same-cycle grant, so no handshake is offered.
        if (win_found && !reset) begin
          grant_oh[win_id] = 1'b1;
          a_d              = a_sel;
          b_d              = b_sel;
          grant_d          = win_id;
          last_d           = win_id;
          state_d          = ADD;
        end
      end
      ADD: begin
        id_d    = grant_q;
        state_d = OUT;
        if (ovf) begin
          sum_d = sat_max;
          sat_d = 1'b1;
        end else if (und) begin
          sum_d = sat_min;
          sat_d = 1'b1;
        end else begin
          sum_d = sm;
          sat_d = 1'b0;
        end
      end
      OUT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      grant_q <= '0;
      last_q  <= last_rst;
      sum_q   <= '0;
      id_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.res_valid = (state_q == OUT);
  assign bus.res_sum   = sum_q;
  assign bus.res_id    = id_q;
  assign bus.res_sat   = sat_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: a cycle model predicts grants and
// queues clamped sums, which are compared whenever a result is presented.
module tb_adder_rr_arbiter;

  localparam int DW = 17;
  localparam int NR = 4;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  typedef struct {
    logic [DW-1:0] sum;
    logic [IW-1:0] id;
    logic          sat;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rdy   = 1'b1;
  logic mon_on = 1'b0;

  adder_rr_arbiter_if #(.data_width(DW), .num_req(NR)) bus ();

  adder_rr_arbiter #(.data_width(DW), .num_req(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   checks   = 0;
  int   failures = 0;
  op_t  opq [NR][$];
  res_t sb [$];
  int   id_log [$];
  int   cyc_log [$];
  int   grant_log [$];
  int   cyc     = 0;
  int   m_state = 0;   // 0 idle, 1 add, 2 out
  int   m_last  = NR - 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t ref_add(input op_t o, input int id);
    res_t r;
    int   s;
    s     = int'($signed(o.a)) + int'($signed(o.b));
    r.sat = 1'b0;
    if (s > 65535) begin
      s = 65535; r.sat = 1'b1;
    end else if (s < -65536) begin
      s = -65536; r.sat = 1'b1;
    end
    r.sum = DW'(s);
    r.id  = IW'(id);
    return r;
  endfunction

  task automatic push_op(input int r, input int a, input int b);
    op_t o;
    o.a = DW'(a);
    o.b = DW'(b);
    opq[r].push_back(o);
  endtask

  function automatic logic busy();
    int n = 0;
    for (int i = 0; i < NR; i++) n += opq[i].size();
    return (n > 0) || (sb.size() > 0) || (m_state != 0);
  endfunction

  task automatic clear_logs();
    id_log.delete();
    cyc_log.delete();
    grant_log.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy() && n < 300) begin
      @(posedge clock); #2;
      n++;
    end
    check({tag, "_timeout"}, 32'(busy()), 32'd0);
  endtask

  task automatic wait_state(input int s, input string tag);
    int n = 0;
    while (m_state != s && n < 100) begin
      @(posedge clock); #2;
      n++;
    end
    check({tag, "_reach"}, 32'(m_state), 32'(s));
  endtask

  // Requester/consumer driver: operands appear just after the edge.
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (opq[i].size() > 0) begin
        bus.req_valid[i]             = 1'b1;
        bus.req_data_1[i*DW +: DW]   = opq[i][0].a;
        bus.req_data_2[i*DW +: DW]   = opq[i][0].b;
      end else begin
        bus.req_valid[i]             = 1'b0;
        bus.req_data_1[i*DW +: DW]   = DW'($urandom);
        bus.req_data_2[i*DW +: DW]   = DW'($urandom);
      end
    end
    bus.res_ready = rdy;
  end

  // Cycle model and scoreboard, evaluated mid-cycle.
  always @(negedge clock) begin
    logic [NR-1:0] exp_rdy;
    int            win;
    int            idx;
    res_t          e;
    cyc++;
    if (mon_on) begin
      exp_rdy = '0;
      win     = -1;
      if (!reset && m_state == 0) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (win < 0 && bus.req_valid[idx[IW-1:0]]) win = idx;
        end
      end
      if (win >= 0) exp_rdy[win[IW-1:0]] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("res_valid", 32'(bus.res_valid), 32'(m_state == 2));
      if (m_state == 2) begin
        check("sb_size", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          e = sb[0];
          check("res_sum", 32'(bus.res_sum), 32'(e.sum));
          check("res_id",  32'(bus.res_id),  32'(e.id));
          check("res_sat", 32'(bus.res_sat), 32'(e.sat));
        end
      end
      if (reset) begin
        m_state = 0;
        m_last  = NR - 1;
        sb.delete();
      end else begin
        case (m_state)
          0: if (win >= 0) begin
            sb.push_back(ref_add(opq[win][0], win));
            void'(opq[win].pop_front());
            grant_log.push_back(cyc);
            m_last  = win;
            m_state = 1;
          end
          1: m_state = 2;
          default: if (bus.res_ready) begin
            if (sb.size() > 0) id_log.push_back(int'(sb[0].id));
            cyc_log.push_back(cyc);
            if (sb.size() > 0) void'(sb.pop_front());
            m_state = 0;
          end
        endcase
      end
    end
  end

  initial begin
    int rr_exp [6];
    rr_exp = '{0, 1, 2, 3, 0, 1};
    bus.req_valid  = '0;
    bus.req_data_1 = '0;
    bus.req_data_2 = '0;
    bus.res_ready  = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    mon_on = 1'b1;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_sum",   32'(bus.res_sum),   32'd0);
    check("rst_res_id",    32'(bus.res_id),    32'd0);
    check("rst_res_sat",   32'(bus.res_sat),   32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;

    // Single request: 100 + -30 from requester 0.
    clear_logs();
    push_op(0, 100, -30);
    wait_idle("single");
    check("single_id",      32'(id_log.size() > 0 ? id_log[0] : -1), 32'd0);
    check("single_latency", 32'(cyc_log.size() > 0 && grant_log.size() > 0 ? cyc_log[0] - grant_log[0] : -1), 32'd2);

    // Saturation corners, all on requester 3.
    push_op(3, 65535, 1);
    push_op(3, -65536, -1);
    push_op(3, -65536, 65535);
    wait_idle("sat");

    // Fairness with every requester valid.
    clear_logs();
    for (int i = 0; i < NR; i++) begin
      push_op(i, int'($urandom_range(131071)) - 65536, int'($urandom_range(131071)) - 65536);
      if (i < 2) push_op(i, int'($urandom_range(131071)) - 65536, int'($urandom_range(131071)) - 65536);
    end
    wait_idle("rr");
    check("rr_count", 32'(id_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < id_log.size()) check("rr_order", 32'(id_log[i]), 32'(rr_exp[i]));
      if (i > 0 && i < cyc_log.size()) check("rr_interval", 32'(cyc_log[i] - cyc_log[i-1]), 32'd3);
    end

    // Backpressure: consumer stalls while a result is pending.
    clear_logs();
    rdy = 1'b0;
    push_op(2, 30000, 40000);
    push_op(2, -7, 9);
    wait_state(2, "bp");
    repeat (5) @(posedge clock);
    #2;
    rdy = 1'b1;
    wait_idle("bp");
    check("bp_held", 32'(cyc_log.size() > 0 && grant_log.size() > 0 && cyc_log[0] - grant_log[0] >= 7), 32'd1);
    check("bp_next_grant", 32'(grant_log.size() > 1 && cyc_log.size() > 0 ? grant_log[1] - cyc_log[0] : -1), 32'd1);

    // Priority skip: last grant 1, then only 0 and 3 valid.
    push_op(1, 11, 22);
    wait_idle("skip_pre");
    clear_logs();
    push_op(0, 5, 6);
    push_op(3, -40, 12);
    wait_idle("skip");
    check("skip_first",  32'(id_log.size() > 0 ? id_log[0] : -1), 32'd3);
    check("skip_second", 32'(id_log.size() > 1 ? id_log[1] : -1), 32'd0);

    // Reset during ADD discards the transaction.
    push_op(2, 1000, 2000);
    wait_state(1, "rst_add");
    reset = 1'b1;
    @(posedge clock);
    #2;
    check("mid_res_valid", 32'(bus.res_valid), 32'd0);
    check("mid_res_sum",   32'(bus.res_sum),   32'd0);
    check("mid_res_id",    32'(bus.res_id),    32'd0);
    check("mid_res_sat",   32'(bus.res_sat),   32'd0);
    reset = 1'b0;
    clear_logs();
    for (int i = 0; i < NR; i++) push_op(i, i * 1000 + 1, -(i * 77));
    wait_idle("post_rst");
    check("post_rst_first", 32'(id_log.size() > 0 ? id_log[0] : -1), 32'd0);
    check("post_rst_count", 32'(id_log.size()), 32'd4);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin scheduler that shares one saturating 17-bit adder stage among `num_req` requesters in the ESPNet datapath. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester at a time, runs the saturating add, and returns the sum tagged with the requester index over a valid/ready result port. It sits between the convolution partial-sum producers and the accumulation stage.

## Interface
- `data_width`, 17: operand and sum width, two's complement.
- `num_req`, 4: number of requesters, ≥2.
- `id_width`, `$clog2(num_req)`: width of the requester tag.

- `clock`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `req_valid`  in  num_req  — bit i: requester i offers operands.
- `req_ready`  out  num_req  — bit i: requester i's operands accepted this cycle (one-hot or zero).
- `req_data_1`  in  num_req*data_width  — operand A; slice i = bits [i*data_width +: data_width].
- `req_data_2`  in  num_req*data_width  — operand B; same packing.
- `res_valid`  out  1  — result available.
- `res_ready`  in  1  — consumer accepts result.
- `res_sum`  out  data_width  — saturated signed sum.
- `res_id`  out  id_width  — index of the requester that owns `res_sum`.
- `res_sat`  out  1  — result was clipped.

## Operation
- FSM states: IDLE, ADD, OUT.
- IDLE:
  - If any `req_valid` is high, the winner is the first requester with valid high, searching from `last_grant+1` upward, modulo `num_req`.
  - `req_ready[winner]` is driven combinationally high in the same cycle.
  - The winner's operands are latched into internal registers A and B. `grant_id` and `last_grant` are set to the winner. Next state is ADD.
  - `req_ready` is all-zero in ADD and OUT, and in IDLE when no request is valid.
- ADD (one cycle): compute `sm = A + B`, truncated to `data_width`.
  - Overflow (A≥0, B≥0, sm<0): `res_sum = 2^(data_width-1)-1`, `res_sat = 1`.
  - Underflow (A<0, B<0, sm≥0): `res_sum = -2^(data_width-1)`, `res_sat = 1`.
  - Otherwise: `res_sum = sm`, `res_sat = 0`.
  - `res_sum`, `res_sat` and `res_id = grant_id` are registered at the end of ADD. Next state is OUT.
- OUT: `res_valid = 1`.
  - `res_sum`, `res_id` and `res_sat` are held stable until `res_ready` is high.
  - On `res_valid & res_ready`, next state is IDLE.
  - No new grant is made while in OUT.
- Requesters may drop or change `req_valid` and data freely before their handshake; operands are sampled only on the handshake cycle.
- Fairness: with all requesters continuously valid, the grant sequence is 0,1,…,num_req-1,0,…

## Timing
- Reset values: state IDLE; `req_ready` 0; `res_valid` 0; `res_sum` 0; `res_id` 0; `res_sat` 0; `last_grant = num_req-1`, so requester 0 has highest priority after reset.
- Reset mid-operation: any in-flight transaction is discarded and no result is emitted. The accepted requester is not re-served unless it re-requests.
- Latency: handshake in cycle T, ADD in T+1, `res_valid` high from T+2.
- If `res_ready` is high at T+2, the FSM is in IDLE at T+3 and the next grant can occur at T+3. Minimum issue interval is 3 cycles.
- Backpressure: `res_valid` stays high and outputs stay unchanged for every cycle `res_ready` is low.
- `res_ready` high while `res_valid` is low has no effect.
- Reset has priority over every other event in the same cycle.

## Test plan
- Single request: after reset, `req_valid=0001`, operands 100 and -30 → `req_ready=0001` in the same cycle; 2 cycles later `res_valid=1`, `res_sum=70`, `res_id=0`, `res_sat=0`.
- Saturation: 65535 + 1 → `res_sum=65535`, `res_sat=1`. -65536 + -1 → `res_sum=-65536`, `res_sat=1`. -65536 + 65535 → `res_sum=-1`, `res_sat=0`.
- Round-robin: all four `req_valid` held high, `res_ready=1` → `res_id` sequence 0,1,2,3,0,1 with results every 3 cycles; `req_ready` is one-hot on each grant.
- Backpressure: hold `res_ready` low for 5 cycles with results pending → outputs are stable, `res_valid=1`, `req_ready=0` throughout. The next grant occurs the cycle after `res_ready` rises.
- Priority skip: `last_grant=1` and only requesters 0 and 3 valid → requester 3 is granted first, then 0.
- Reset mid-ADD: assert reset during ADD → `res_valid` stays 0 and all outputs are 0. With all requesters valid afterwards, the first grant goes to requester 0.
